sd_rsp_receiver: RTL and testbench

- Host-side receiver for SD card responses on the CMD line. It is the writer side of sd_registers.
- Deserializes 48-bit (R1/R1b/R3/R6/R7) and 136-bit (R2) frames and checks start, transmission, index, CRC7 and end bits.
- On a good frame it produces the *_in data and one-cycle *_en strobes for CID, CSD, OCR, RCA and STATUS.
- Sits between the CMD pad sampler and sd_registers; armed by the command transmitter after each command's end bit.

---
 rtl/sd_pkg.sv | 13 +
 rtl/sd_rsp_receiver_if.sv | 24 ++
 rtl/sd_crc7.sv | 21 ++
 rtl/sd_rsp_receiver.sv | 148 ++++++++++++++
 tb/tb_sd_rsp_receiver.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: shared SD response encodings, frame lengths and CRC constants
package sd_pkg;
  typedef enum logic [2:0] {
    RSP_NONE, RSP_R1, RSP_R1B, RSP_R2_CID, RSP_R2_CSD, RSP_R3, RSP_R6, RSP_R7
  } rsp_type_e;
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_RECV, S_CHECK, S_WAIT_BUSY, S_DONE
  } state_e;
  localparam int        LEN_SHORT = 48;
  localparam int        LEN_LONG  = 136;
  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam logic [5:0] IDX_NONE  = 6'h3F;
endpackage

// File: rtl/sd_rsp_receiver_if.sv
// sd_rsp_receiver_if: CMD/DAT0 sampling inputs, arm controls and register-write outputs
interface sd_rsp_receiver_if;
  logic         sample_en, cmd_in, dat0_in, rsp_start;
  logic [2:0]   rsp_type;
  logic [5:0]   exp_index;
  logic         busy, done, timeout_err, crc_err, frame_err, index_err;
  logic [127:0] cid_in, csd_in;
  logic [31:0]  ocr_in;
  logic [15:0]  rca_in;
  logic [63:0]  stat_in;
  logic         cid_en, csd_en, ocr_en, rca_en, stat_en;
  modport master (
    output sample_en, cmd_in, dat0_in, rsp_start, rsp_type, exp_index,
    input  busy, done, timeout_err, crc_err, frame_err, index_err,
    input  cid_in, csd_in, ocr_in, rca_in, stat_in,
    input  cid_en, csd_en, ocr_en, rca_en, stat_en
  );
  modport slave (
    input  sample_en, cmd_in, dat0_in, rsp_start, rsp_type, exp_index,
    output busy, done, timeout_err, crc_err, frame_err, index_err,
    output cid_in, csd_in, ocr_in, rca_in, stat_in,
    output cid_en, csd_en, ocr_en, rca_en, stat_en
  );
endinterface

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1), MSB-first, with clear and enable
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_din,
  output logic [6:0] o_crc
);
  logic [6:0] r_crc;
  logic       w_fb;
  assign w_fb  = i_din ^ r_crc[6];
  assign o_crc = r_crc;
  // shift one bit through the LFSR when enabled; clear has priority
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_crc <= '0;
    else if (i_clr) r_crc <= '0;
    else if (i_en) r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
endmodule

// File: rtl/sd_rsp_receiver.sv
// sd_rsp_receiver: deserialize and check SD CMD-line responses, emit register writes
module sd_rsp_receiver
  import sd_pkg::*;
#(
  parameter int NCR_MAX  = 64,
  parameter int BUSY_MAX = 65535
) (
  input  logic clk,
  input  logic reset,
  sd_rsp_receiver_if.slave bus
);
  localparam logic [15:0] NCR_LAST  = 16'(NCR_MAX - 1);
  localparam logic [15:0] BUSY_LAST = 16'(BUSY_MAX - 1);
  localparam logic [15:0] LAST_S    = 16'(LEN_SHORT - 1);
  localparam logic [15:0] LAST_L    = 16'(LEN_LONG - 1);
  state_e       r_state, w_next;
  rsp_type_e    r_type;
  logic [5:0]   r_exp;
  logic [15:0]  r_cnt;
  logic [135:0] r_sr;
  logic         r_busy, r_timeout, r_crc_err, r_frame_err, r_index_err;
  logic [127:0] r_cid, r_csd;
  logic [31:0]  r_ocr;
  logic [15:0]  r_rca;
  logic [63:0]  r_stat;
  logic [6:0]   w_crc;
  logic         w_accept, w_long, w_take, w_crc_en, w_frame_bad, w_idx_bad, w_crc_bad;
  logic         w_chk_bad, w_ncr_to, w_busy_to, w_busy_hit, w_load, w_ok;
  logic [15:0]  w_bit, w_last;
  logic [5:0]   w_rx_idx;
  logic [31:0]  w_pay;

  assign w_accept    = r_state == S_IDLE && bus.rsp_start;
  assign w_long      = r_type inside {RSP_R2_CID, RSP_R2_CSD};
  assign w_last      = w_long ? LAST_L : LAST_S;
  assign w_take      = bus.sample_en && ((r_state == S_WAIT_START && !bus.cmd_in) || r_state == S_RECV);
  assign w_bit       = r_state == S_RECV ? r_cnt : 16'd0;
  assign w_crc_en    = w_take && (w_long ? (w_bit >= 16'd8 && w_bit < 16'd128) : w_bit < 16'd40);
  assign w_rx_idx    = r_sr[45:40];
  assign w_pay       = r_sr[39:8];
  assign w_frame_bad = (w_long ? (r_sr[135] || r_sr[134]) : (r_sr[47] || r_sr[46])) || !r_sr[0];
  assign w_idx_bad   = r_type inside {RSP_R1, RSP_R1B, RSP_R6, RSP_R7} && w_rx_idx != r_exp;
  assign w_crc_bad   = r_type != RSP_R3 && w_crc != r_sr[7:1];
  assign w_chk_bad   = w_frame_bad || w_idx_bad || w_crc_bad;
  assign w_ncr_to    = r_state == S_WAIT_START && bus.sample_en && bus.cmd_in && r_cnt == NCR_LAST;
  assign w_busy_hit  = r_state == S_WAIT_BUSY && bus.sample_en && bus.dat0_in;
  assign w_busy_to   = r_state == S_WAIT_BUSY && bus.sample_en && !bus.dat0_in && r_cnt == BUSY_LAST;
  assign w_load      = (r_state == S_CHECK && !w_chk_bad && r_type != RSP_R1B) || w_busy_hit;
  assign w_ok        = r_state == S_DONE && !(r_timeout || r_crc_err || r_frame_err || r_index_err);

  assign bus.busy        = r_busy;
  assign bus.done        = r_state == S_DONE;
  assign bus.timeout_err = r_timeout;
  assign bus.crc_err     = r_crc_err;
  assign bus.frame_err   = r_frame_err;
  assign bus.index_err   = r_index_err;
  assign bus.cid_in      = r_cid;
  assign bus.csd_in      = r_csd;
  assign bus.ocr_in      = r_ocr;
  assign bus.rca_in      = r_rca;
  assign bus.stat_in     = r_stat;
  assign bus.cid_en      = w_ok && r_type == RSP_R2_CID;
  assign bus.csd_en      = w_ok && r_type == RSP_R2_CSD;
  assign bus.ocr_en      = w_ok && r_type == RSP_R3;
  assign bus.rca_en      = w_ok && r_type == RSP_R6;
  assign bus.stat_en     = w_ok && r_type inside {RSP_R1, RSP_R1B, RSP_R6, RSP_R7};

  sd_crc7 u_crc (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_accept),
    .i_en  (w_crc_en),
    .i_din (bus.cmd_in),
    .o_crc (w_crc)
  );

  // next-state logic for the receive sequence
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (bus.rsp_start) w_next = bus.rsp_type == 3'd0 ? S_DONE : S_WAIT_START;
      S_WAIT_START: w_next = w_take ? S_RECV : w_ncr_to ? S_DONE : S_WAIT_START;
      S_RECV:       if (w_take && r_cnt == w_last) w_next = S_CHECK;
      S_CHECK:      w_next = (r_type == RSP_R1B && !w_chk_bad) ? S_WAIT_BUSY : S_DONE;
      S_WAIT_BUSY:  if (w_busy_hit || w_busy_to) w_next = S_DONE;
      default:      w_next = S_IDLE;
    endcase
  end

  // state, latched request, busy, bit/idle counter and shift register
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= S_IDLE;
      r_type  <= RSP_NONE;
      r_exp   <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_next;
      r_type  <= w_accept ? rsp_type_e'(bus.rsp_type) : r_type;
      r_exp   <= w_accept ? bus.exp_index : r_exp;
      r_busy  <= w_accept ? bus.rsp_type != 3'd0 : r_state == S_DONE ? 1'b0 : r_busy;
      r_cnt   <= (w_accept || r_state == S_CHECK) ? 16'd0
               : (bus.sample_en && r_state inside {S_WAIT_START, S_RECV, S_WAIT_BUSY})
                 ? ((r_state == S_WAIT_START && !bus.cmd_in) ? 16'd1 : r_cnt + 16'd1)
               : r_cnt;
      r_sr    <= w_accept ? '0 : w_take ? {r_sr[134:0], bus.cmd_in} : r_sr;
    end

  // sticky error flags, cleared by an accepted arm
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_timeout   <= 1'b0;
      r_crc_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_index_err <= 1'b0;
    end else if (w_accept) begin
      r_timeout   <= 1'b0;
      r_crc_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_index_err <= 1'b0;
    end else begin
      r_timeout   <= r_timeout | w_ncr_to | w_busy_to;
      r_crc_err   <= r_crc_err | (r_state == S_CHECK && w_crc_bad);
      r_frame_err <= r_frame_err | (r_state == S_CHECK && w_frame_bad);
      r_index_err <= r_index_err | (r_state == S_CHECK && w_idx_bad);
    end

  // register data, updated only on the way into DONE for a clean frame
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cid  <= '0;
      r_csd  <= '0;
      r_ocr  <= '0;
      r_rca  <= '0;
      r_stat <= '0;
    end else if (w_load) begin
      if (r_type inside {RSP_R1, RSP_R1B, RSP_R7}) r_stat <= {26'd0, w_rx_idx, w_pay};
      if (r_type == RSP_R6) begin
        r_rca  <= w_pay[31:16];
        r_stat <= {26'd0, w_rx_idx, 8'd0, w_pay[15], w_pay[14], 2'd0, w_pay[13], 6'd0, w_pay[12:0]};
      end
      if (r_type == RSP_R3) r_ocr <= w_pay;
      if (r_type == RSP_R2_CID) r_cid <= {r_sr[127:1], 1'b1};
      if (r_type == RSP_R2_CSD) r_csd <= {r_sr[127:1], 1'b1};
    end
endmodule

// File: tb/tb_sd_rsp_receiver.sv
// tb_sd_rsp_receiver: table-driven and hand-sequenced checks of the SD response receiver
module tb_sd_rsp_receiver;
  import sd_pkg::*;

  typedef struct {
    logic [2:0]   rtype;
    logic [5:0]   eidx;
    logic [135:0] frame;
    int           nbits;
    logic [3:0]   err;
    logic [4:0]   en;
    logic [63:0]  stat;
    logic [15:0]  rca;
    logic [31:0]  ocr;
    logic [127:0] r2;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  sd_rsp_receiver_if bus ();

  sd_rsp_receiver #(.NCR_MAX(64), .BUSY_MAX(65535)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  logic [4:0] en_seen;
  logic [127:0] m_cid, m_csd;
  logic [31:0]  m_ocr;
  logic [15:0]  m_rca;
  logic [63:0]  m_stat;
  vec_t vt[11];

  always @(negedge clk)
    if (bus.done) begin
      n_done++;
      en_seen = {bus.cid_en, bus.csd_en, bus.ocr_en, bus.rca_en, bus.stat_en};
    end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [6:0] crc7(input logic [119:0] d, input int n);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [135:0] mk48(input logic [39:0] b);
    return {88'd0, b, crc7({80'd0, b}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] mk136(input logic [119:0] b);
    return {2'b00, IDX_NONE, b, crc7(b, 120), 1'b1};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.cmd_in = b;
    bus.sample_en = 1'b1;
    tick();
    bus.sample_en = 1'b0;
    tick();
  endtask

  task automatic arm(input logic [2:0] t, input logic [5:0] idx);
    bus.rsp_type  = t;
    bus.exp_index = idx;
    bus.rsp_start = 1'b1;
    tick();
    bus.rsp_start = 1'b0;
  endtask

  task automatic send_frame(input logic [135:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(f[i]);
    bus.cmd_in = 1'b1;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".cid_in"}, bus.cid_in, m_cid);
    chk({nm, ".csd_in"}, bus.csd_in, m_csd);
    chk({nm, ".ocr_in"}, {96'd0, bus.ocr_in}, {96'd0, m_ocr});
    chk({nm, ".rca_in"}, {112'd0, bus.rca_in}, {112'd0, m_rca});
    chk({nm, ".stat_in"}, {64'd0, bus.stat_in}, {64'd0, m_stat});
  endtask

  task automatic run_vec(input int k);
    string nm;
    nm = $sformatf("vec%0d", k);
    arm(vt[k].rtype, vt[k].eidx);
    repeat (5) send_bit(1'b1);
    send_frame(vt[k].frame, vt[k].nbits);
    chk({nm, ".done"}, {127'd0, bus.done}, 128'd1);
    chk({nm, ".err"}, {124'd0, bus.timeout_err, bus.crc_err, bus.frame_err, bus.index_err}, {124'd0, vt[k].err});
    chk({nm, ".en"}, {123'd0, bus.cid_en, bus.csd_en, bus.ocr_en, bus.rca_en, bus.stat_en}, {123'd0, vt[k].en});
    if (vt[k].err == 4'd0) begin
      if (vt[k].en[0]) m_stat = vt[k].stat;
      if (vt[k].en[1]) m_rca  = vt[k].rca;
      if (vt[k].en[2]) m_ocr  = vt[k].ocr;
      if (vt[k].en[3]) m_csd  = vt[k].r2;
      if (vt[k].en[4]) m_cid  = vt[k].r2;
    end
    chk_model(nm);
    tick();
    chk({nm, ".busy_after"}, {126'd0, bus.busy, bus.done}, 128'd0);
  endtask

  initial begin
    logic [119:0] cid_b, csd_b;
    logic [135:0] f;
    int d0;
    reset = 1'b0;
    bus.sample_en = 1'b0;
    bus.cmd_in = 1'b1;
    bus.dat0_in = 1'b1;
    bus.rsp_start = 1'b0;
    bus.rsp_type = 3'd0;
    bus.exp_index = 6'd0;
    {m_cid, m_csd, m_ocr, m_rca, m_stat} = '0;
    cid_b = 120'h0011_2233_4455_6677_8899_AABB_CCDD_EE;
    csd_b = 120'h400E_0032_5B59_0000_3B37_7F80_0A40_00;
    vt[0]  = '{rtype:3'd7, eidx:6'd8,  frame:{88'd0, 48'h08_000001AA_13}, nbits:48, err:4'b0000, en:5'b00001,
               stat:64'h0000_0008_0000_01AA, rca:16'd0, ocr:32'd0, r2:128'd0};
    vt[1]  = '{rtype:3'd7, eidx:6'd8,  frame:{88'd0, 48'h08_000001AA_15}, nbits:48, err:4'b0100, en:5'b00000,
               stat:64'd0, rca:16'd0, ocr:32'd0, r2:128'd0};
    vt[2]  = '{rtype:3'd6, eidx:6'd3,  frame:mk48(40'h03_1234_0500), nbits:48, err:4'b0000, en:5'b00011,
               stat:64'h0000_0003_0000_0500, rca:16'h1234, ocr:32'd0, r2:128'd0};
    f = mk136(cid_b);
    vt[3]  = '{rtype:3'd3, eidx:6'd0,  frame:f, nbits:136, err:4'b0000, en:5'b10000,
               stat:64'd0, rca:16'd0, ocr:32'd0, r2:f[127:0]};
    vt[4]  = '{rtype:3'd3, eidx:6'd0,  frame:f ^ (136'd1 << 60), nbits:136, err:4'b0100, en:5'b00000,
               stat:64'd0, rca:16'd0, ocr:32'd0, r2:128'd0};
    vt[5]  = '{rtype:3'd5, eidx:6'd0,  frame:{88'd0, 48'h3F_80FF8000_FF}, nbits:48, err:4'b0000, en:5'b00100,
               stat:64'd0, rca:16'd0, ocr:32'h80FF_8000, r2:128'd0};
    vt[6]  = '{rtype:3'd1, eidx:6'd17, frame:mk48(40'h10_0000_0900), nbits:48, err:4'b0001, en:5'b00000,
               stat:64'd0, rca:16'd0, ocr:32'd0, r2:128'd0};
    vt[7]  = '{rtype:3'd1, eidx:6'd17, frame:mk48(40'h11_0000_0900) & ~136'd1, nbits:48, err:4'b0010, en:5'b00000,
               stat:64'd0, rca:16'd0, ocr:32'd0, r2:128'd0};
    f = mk136(csd_b);
    vt[8]  = '{rtype:3'd4, eidx:6'd0,  frame:f, nbits:136, err:4'b0000, en:5'b01000,
               stat:64'd0, rca:16'd0, ocr:32'd0, r2:f[127:0]};
    vt[9]  = '{rtype:3'd1, eidx:6'd17, frame:mk48(40'h51_0000_0000), nbits:48, err:4'b0010, en:5'b00000,
               stat:64'd0, rca:16'd0, ocr:32'd0, r2:128'd0};
    vt[10] = '{rtype:3'd1, eidx:6'd17, frame:mk48(40'h11_0000_0900), nbits:48, err:4'b0000, en:5'b00001,
               stat:64'h0000_0011_0000_0900, rca:16'd0, ocr:32'd0, r2:128'd0};

    repeat (3) tick();
    chk("reset.ctl", {122'd0, bus.busy, bus.done, bus.timeout_err, bus.crc_err, bus.frame_err, bus.index_err}, 128'd0);
    chk_model("reset");
    reset = 1'b1;
    tick();

    for (int k = 0; k < 11; k++) run_vec(k);

    // type 0: done the following cycle, no busy, no strobes
    arm(3'd0, 6'd0);
    chk("none.done", {127'd0, bus.done}, 128'd1);
    chk("none.busy_en", {122'd0, bus.busy, bus.cid_en, bus.csd_en, bus.ocr_en, bus.rca_en, bus.stat_en}, 128'd0);
    tick();

    // arm while busy is ignored, latched exp_index kept
    arm(3'd7, 6'd8);
    repeat (3) send_bit(1'b1);
    bus.rsp_type = 3'd0;
    bus.exp_index = 6'd9;
    bus.rsp_start = 1'b1;
    tick();
    bus.rsp_start = 1'b0;
    chk("rearm.busy", {127'd0, bus.busy}, 128'd1);
    repeat (2) send_bit(1'b1);
    send_frame(vt[0].frame, 48);
    chk("rearm.done_en", {122'd0, bus.done, bus.index_err, bus.crc_err, bus.timeout_err, bus.stat_en, bus.rca_en},
        {122'd0, 6'b100010});
    tick();

    // NCR timeout at the 64th idle sample
    arm(3'd1, 6'd1);
    d0 = n_done;
    repeat (63) send_bit(1'b1);
    chk("ncr.pre_done", {96'd0, 32'(n_done - d0), 31'd0, bus.busy}, {96'd0, 32'd0, 32'd1});
    send_bit(1'b1);
    chk("ncr.done_cnt", 128'(n_done - d0), 128'd1);
    chk("ncr.err_en", {119'd0, bus.timeout_err, bus.crc_err, bus.frame_err, bus.index_err, en_seen}, {119'd0, 9'b1000_00000});
    chk("ncr.busy", {127'd0, bus.busy}, 128'd0);

    // R1b: DAT0 held low 100 bits, then released
    bus.dat0_in = 1'b0;
    arm(3'd2, 6'd7);
    repeat (2) send_bit(1'b1);
    send_frame(mk48(40'h07_0000_0B00), 48);
    repeat (100) send_bit(1'b1);
    chk("r1b.waiting", {126'd0, bus.busy, bus.done}, 128'd2);
    bus.dat0_in = 1'b1;
    bus.sample_en = 1'b1;
    tick();
    bus.sample_en = 1'b0;
    m_stat = 64'h0000_0007_0000_0B00;
    chk("r1b.done_en", {125'd0, bus.done, bus.stat_en, bus.timeout_err}, {125'd0, 3'b110});
    chk_model("r1b");
    tick();
    chk("r1b.busy_after", {127'd0, bus.busy}, 128'd0);

    // reset mid-RECV aborts silently, then a clean R3
    arm(3'd1, 6'd17);
    send_frame(mk48(40'h11_0000_0900) >> 30, 18);
    d0 = n_done;
    reset = 1'b0;
    #1;
    chk("abort.busy", {126'd0, bus.busy, bus.done}, 128'd0);
    {m_cid, m_csd, m_ocr, m_rca, m_stat} = '0;
    tick();
    tick();
    chk("abort.no_done", 128'(n_done - d0), 128'd0);
    chk_model("abort");
    reset = 1'b1;
    tick();
    run_vec(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
